gray_counter_param: RTL and testbench

- Parametrised up/down counter with an internal binary state.
- Drives a registered binary output and a registered Gray-coded output of the same count, so the two always describe one value on every cycle.
- Adds enable, direction, synchronous clear/load, optional saturation, a terminal-count flag and a wrap pulse.
- Serves as the common counter for pixel/ADC timing paths and for Gray-coded pointers crossing clock domains.

---
 rtl/gray_counter_pkg.sv | 24 ++
 rtl/gray_step_next.sv | 41 ++++
 rtl/gray_counter_param.sv | 72 +++++++
 tb/tb_gray_counter_param.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_counter_pkg.sv
// Shared definitions for the binary/Gray up-down counter and its downstream users.
// Conversion helpers work on a max-width vector; callers cast to their own width.
package gray_counter_pkg;

    localparam int unsigned MAX_WIDTH = 32;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
        logic [MAX_WIDTH-1:0] b;
        b = g;
        for (int i = 1; i < int'(MAX_WIDTH); i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_step_next.sv
// Next-state logic for the counter: priority clr > load > en > hold,
// plus the terminal-count flag and the wrap indication for the next cycle.
module gray_step_next
    import gray_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter bit          SATURATE = 1'b0
) (
    input  logic [WIDTH-1:0] bin,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] next_bin,
    output logic             tc,
    output logic             wrap_next
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    assign tc = (up == DIR_UP) ? (bin == {WIDTH{1'b1}}) : (bin == '0);

    always_comb begin
        next_bin  = bin;
        wrap_next = 1'b0;
        if (clr) begin
            next_bin = '0;
        end else if (load) begin
            next_bin = load_val;
        end else if (en) begin
            if (tc && SATURATE) begin
                next_bin = bin;
            end else begin
                next_bin  = (up == DIR_UP) ? (bin + ONE) : (bin - ONE);
                wrap_next = tc;
            end
        end
    end

endmodule

// File: rtl/gray_counter_param.sv
// Up/down counter presenting the same count as registered binary and Gray outputs.
// Gray is registered from next_bin so both outputs always describe one value.
module gray_counter_param
    import gray_counter_pkg::*;
#(
    parameter int unsigned WIDTH           = 8,
    parameter bit          SATURATE        = 1'b0,
    parameter bit          STEP_GRAY_CHECK = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] valuegray,
    output logic             tc,
    output logic             wrap
);

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic             wrap_q;
    logic [WIDTH-1:0] next_bin;
    logic [WIDTH-1:0] gray_next;
    logic             wrap_next;

    gray_step_next #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_step (
        .bin       (bin_q),
        .en        (en),
        .up        (up),
        .clr       (clr),
        .load      (load),
        .load_val  (load_val),
        .next_bin  (next_bin),
        .tc        (tc),
        .wrap_next (wrap_next)
    );

    assign gray_next = WIDTH'(bin2gray(MAX_WIDTH'(next_bin)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= next_bin;
            gray_q <= gray_next;
            wrap_q <= wrap_next;
        end
    end

    assign value     = bin_q;
    assign valuegray = gray_q;
    assign wrap      = wrap_q;

    // Load and clr may jump arbitrarily; only genuine count steps must be single-bit.
    if (STEP_GRAY_CHECK) begin : g_gray_check
        logic counted;
        assign counted = en && !clr && !load && (next_bin != bin_q);

        a_gray_one_bit: assert property (@(posedge clk) disable iff (!reset)
            counted |-> $onehot(gray_next ^ gray_q));
    end

endmodule

// File: tb/tb_gray_counter_param.sv
// Scoreboard bench: a wrapping and a saturating 8-bit counter share stimulus;
// an arithmetic reference model queues expectations that a monitor checks each cycle.
module tb_gray_counter_param;
    import gray_counter_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       up;
    logic       clr;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] value0, gray0, value1, gray1;
    logic       tc0, wrap0, tc1, wrap1;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        int v[2];
        int g[2];
        bit w[2];
        bit t[2];
        bit s[2];
    } exp_t;

    exp_t sbq[$];
    int   cnt[2];
    bit   sat[2] = '{1'b0, 1'b1};

    always #5 clk = ~clk;

    gray_counter_param #(
        .WIDTH           (8),
        .SATURATE        (1'b0),
        .STEP_GRAY_CHECK (1'b1)
    ) u_wrap (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .up        (up),
        .clr       (clr),
        .load      (load),
        .load_val  (load_val),
        .value     (value0),
        .valuegray (gray0),
        .tc        (tc0),
        .wrap      (wrap0)
    );

    gray_counter_param #(
        .WIDTH           (8),
        .SATURATE        (1'b1),
        .STEP_GRAY_CHECK (1'b1)
    ) u_sat (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .up        (up),
        .clr       (clr),
        .load      (load),
        .load_val  (load_val),
        .value     (value1),
        .valuegray (gray1),
        .tc        (tc1),
        .wrap      (wrap1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    // Drive one cycle of controls and queue what both counters should show after the edge.
    task automatic cycle(input bit e, input bit u, input bit c, input bit l, input int lv);
        exp_t x;
        @(negedge clk);
        en       = e;
        up       = u;
        clr      = c;
        load     = l;
        load_val = lv[7:0];
        for (int d = 0; d < 2; d++) begin
            int old;
            int nxt;
            int raw;
            bit wr;
            old = cnt[d];
            nxt = old;
            wr  = 1'b0;
            if (c) begin
                nxt = 0;
            end else if (l) begin
                nxt = lv % 256;
            end else if (e) begin
                raw = u ? old + 1 : old - 1;
                if (raw < 0 || raw > 255) begin
                    if (sat[d]) begin
                        nxt = old;
                    end else begin
                        nxt = (raw + 256) % 256;
                        wr  = 1'b1;
                    end
                end else begin
                    nxt = raw;
                end
            end
            x.v[d] = nxt;
            x.g[d] = nxt ^ (nxt / 2);
            x.w[d] = wr;
            x.t[d] = u ? (nxt == 255) : (nxt == 0);
            x.s[d] = e && !c && !l && (nxt != old);
            cnt[d] = nxt;
        end
        sbq.push_back(x);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " value[0]"}, 32'(value0), 32'd0);
        chk({tag, " gray[0]"},  32'(gray0),  32'd0);
        chk({tag, " wrap[0]"},  32'(wrap0),  32'd0);
        chk({tag, " tc[0]"},    32'(tc0),    32'(!up));
        chk({tag, " value[1]"}, 32'(value1), 32'd0);
        chk({tag, " gray[1]"},  32'(gray1),  32'd0);
        chk({tag, " wrap[1]"},  32'(wrap1),  32'd0);
        chk({tag, " tc[1]"},    32'(tc1),    32'(!up));
    endtask

    // Assert reset between edges; outputs must clear before any clock edge.
    task automatic reset_mid();
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_zero("async_reset");
        en   = 1'b0;
        clr  = 1'b0;
        load = 1'b0;
        @(negedge clk);
        #2;
        reset  = 1'b1;
        cnt[0] = 0;
        cnt[1] = 0;
    endtask

    initial begin : monitor
        logic [7:0] pg[2];
        logic [7:0] av;
        logic [7:0] ag;
        logic       aw;
        logic       at;
        exp_t       x;
        pg[0] = 8'd0;
        pg[1] = 8'd0;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                x = sbq.pop_front();
                for (int d = 0; d < 2; d++) begin
                    av = (d == 0) ? value0 : value1;
                    ag = (d == 0) ? gray0  : gray1;
                    aw = (d == 0) ? wrap0  : wrap1;
                    at = (d == 0) ? tc0    : tc1;
                    chk($sformatf("value[%0d]", d), 32'(av), 32'(x.v[d]));
                    chk($sformatf("valuegray[%0d]", d), 32'(ag), 32'(x.g[d]));
                    chk($sformatf("wrap[%0d]", d), 32'(aw), 32'(x.w[d]));
                    chk($sformatf("tc[%0d]", d), 32'(at), 32'(x.t[d]));
                    if (x.s[d]) begin
                        chk($sformatf("gray_one_bit_step[%0d]", d),
                            32'($countones(ag ^ pg[d])), 32'd1);
                    end
                end
            end
            pg[0] = gray0;
            pg[1] = gray1;
        end
    end

    initial begin : stimulus
        reset    = 1'b0;
        en       = 1'b0;
        up       = 1'b1;
        clr      = 1'b0;
        load     = 1'b0;
        load_val = 8'd0;
        cnt[0]   = 0;
        cnt[1]   = 0;
        #1;
        check_zero("reset");
        #10;
        reset = 1'b1;

        // Full count-up sweep including the 255 -> 0 rollover.
        repeat (300) cycle(1'b1, 1'b1, 1'b0, 1'b0, 0);

        // load beats en; clr beats load.
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 'hA5);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 'hA5);

        // Count down from 3 through the bottom end.
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 3);
        repeat (5) cycle(1'b1, 1'b0, 1'b0, 1'b0, 0);

        // Direction reversal at 0x40.
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 'h40);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 0);

        // At the top, a winning load or clr suppresses the wrap pulse.
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 'hFF);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 'h10);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 'hFF);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 'hFF);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 0);

        for (int i = 0; i < 500; i++) begin
            cycle($urandom_range(99) < 75, $urandom_range(1) == 1, $urandom_range(99) < 4,
                  $urandom_range(99) < 7, int'($urandom_range(255)));
        end

        // Async reset mid-count at 0x7E, then resume.
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 'h7D);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 0);
        reset_mid();
        repeat (3) cycle(1'b1, 1'b1, 1'b0, 1'b0, 0);

        // Async reset cancels a wrap pulse that is being shown.
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 'hFF);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 0);
        reset_mid();
        repeat (2) cycle(1'b1, 1'b1, 1'b0, 1'b0, 0);

        for (int i = 0; i < 5 && sbq.size() > 0; i++) @(negedge clk);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
